// File: rtl/div_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_if
// Description : Request/response bundle between the execute-stage ALU and the
//               iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_iter_if;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready
  );
endinterface
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative radix-2 restoring 32-bit signed/unsigned divider,
//               one quotient bit per cycle, result = {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter (
  input  wire        clk,
  input  wire        rst,
  div_iter_if.slave  div_bus
);

  localparam logic [5:0] c_ITER = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_signed;
  logic [31:0] r_dividend;
  logic        r_div_neg;
  logic [31:0] r_dmag;
  // Partial remainder never reaches the divisor, so its upper half fits in
  // 32 bits; the 33rd bit of the shifted remainder is r_work[63].
  logic [63:0] r_work;
  logic [5:0]  r_cnt;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_accept;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_part;
  logic [32:0] w_diff;
  logic        w_quot_neg;
  logic        w_rem_neg;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  assign w_accept   = div_bus.start & ~div_bus.annul;
  assign w_mag1     = (div_bus.signed_div & div_bus.opdata1[31]) ? (32'd0 - div_bus.opdata1)
                                                                 : div_bus.opdata1;
  assign w_mag2     = (div_bus.signed_div & div_bus.opdata2[31]) ? (32'd0 - div_bus.opdata2)
                                                                 : div_bus.opdata2;
  assign w_part     = r_work[63:31];
  assign w_diff     = w_part - {1'b0, r_dmag};
  assign w_quot_neg = r_signed & (r_dividend[31] ^ r_div_neg);
  assign w_rem_neg  = r_signed & r_dividend[31];
  assign w_quot_fix = w_quot_neg ? (32'd0 - r_work[31:0])  : r_work[31:0];
  assign w_rem_fix  = w_rem_neg  ? (32'd0 - r_work[63:32]) : r_work[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (div_bus.opdata2 == 32'd0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        w_next = div_bus.annul ? S_IDLE : S_DONE;
      end
      S_ON: begin
        if (div_bus.annul) begin
          w_next = S_IDLE;
        end else if (r_cnt == c_ITER) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!div_bus.start) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_signed   <= 1'b0;
      r_dividend <= 32'd0;
      r_div_neg  <= 1'b0;
      r_dmag     <= 32'd0;
      r_work     <= 64'd0;
      r_cnt      <= 6'd0;
      r_result   <= 64'd0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_signed   <= div_bus.signed_div;
            r_dividend <= div_bus.opdata1;
            r_div_neg  <= div_bus.opdata2[31];
            r_dmag     <= w_mag2;
            r_work     <= {32'd0, w_mag1};
            r_cnt      <= 6'd0;
          end
        end
        S_BYZERO: begin
          if (!div_bus.annul) begin
            r_result <= {r_dividend, 32'hFFFF_FFFF};
            r_ready  <= 1'b1;
          end
        end
        S_ON: begin
          if (!div_bus.annul) begin
            if (r_cnt == c_ITER) begin
              r_result <= {w_rem_fix, w_quot_fix};
              r_ready  <= 1'b1;
            end else begin
              // Negative difference restores: keep the shifted remainder.
              r_work <= w_diff[32] ? {r_work[62:0], 1'b0}
                                   : {w_diff[31:0], r_work[30:0], 1'b1};
              r_cnt  <= r_cnt + 6'd1;
            end
          end
        end
        S_DONE: begin
          if (!div_bus.start) begin
            r_result <= 64'd0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= 64'd0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign div_bus.result = r_result;
  assign div_bus.ready  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Scoreboard testbench for div_iter (latency, corners, annul,
//               divide-by-zero, operand stability, mid-operation reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [63:0] exp_q[$];

  div_iter_if u_if();

  div_iter u_dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sg) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one operation, hold start until ready, then release it.
  task automatic do_op(input string tag, input bit sg, input logic [31:0] a,
                       input logic [31:0] b, input bit scramble);
    int   lat;
    int   exp_lat;
    logic got;
    logic [63:0] exp_r;
    u_if.signed_div = sg;
    u_if.opdata1    = a;
    u_if.opdata2    = b;
    u_if.start      = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(sg, a, b));
    exp_lat = (b == 32'd0) ? 1 : 33;
    #1;
    lat = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      if (scramble) begin
        u_if.opdata1 = $urandom;
        u_if.opdata2 = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
      got = u_if.ready;
    end
    chk_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    exp_r = exp_q.pop_front();
    if (got) begin
      chk_eq({tag, "_res"}, u_if.result, exp_r);
      @(posedge clk);
      #1;
      chk_eq({tag, "_hold"}, {u_if.result[62:0], u_if.ready}, {exp_r[62:0], 1'b1});
    end
    u_if.start = 1'b0;
    @(posedge clk);
    #1;
    chk_eq({tag, "_drop"}, {u_if.result, 63'd0, u_if.ready} >> 63, 64'd0);
    chk_eq({tag, "_dropres"}, u_if.result, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    u_if.signed_div = 1'b0;
    u_if.opdata1 = 32'd0;
    u_if.opdata2 = 32'd0;
    u_if.start = 1'b0;
    u_if.annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_ready", {63'd0, u_if.ready}, 64'd0);
    chk_eq("reset_result", u_if.result, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("u_100_7",    1'b0, 32'd100, 32'd7, 1'b0);
    do_op("s_m7_2",     1'b1, -32'sd7, 32'd2, 1'b0);
    do_op("s_7_m2",     1'b1, 32'd7, -32'sd2, 1'b0);
    do_op("s_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("u_max_16",   1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0);
    do_op("u_min_m1",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("u_div0",     1'b0, 32'h1234_5678, 32'd0, 1'b0);
    do_op("s_div0",     1'b1, 32'h1234_5678, 32'd0, 1'b0);
    do_op("s_scramble", 1'b1, -32'sd1000, 32'd37, 1'b1);
    do_op("u_scramble", 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_op("rand", 1'($urandom), $urandom, $urandom >> $urandom_range(0, 30), 1'b0);
    end

    // Annul ten cycles into ON: the operation must vanish without a result.
    u_if.signed_div = 1'b0;
    u_if.opdata1 = 32'd1000;
    u_if.opdata2 = 32'd3;
    u_if.start = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    u_if.annul = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("annul_ready", {63'd0, u_if.ready}, 64'd0);
    chk_eq("annul_result", u_if.result, 64'd0);
    u_if.annul = 1'b0;
    u_if.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if.ready) seen = 1;
    end
    chk_eq("annul_noready", 64'(seen), 64'd0);
    do_op("after_annul", 1'b0, 32'd50, 32'd5, 1'b0);

    // Annul in IDLE blocks acceptance even with start high.
    u_if.opdata1 = 32'd9;
    u_if.opdata2 = 32'd3;
    u_if.start = 1'b1;
    u_if.annul = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if.ready) seen = 1;
    end
    chk_eq("idle_annul_block", 64'(seen), 64'd0);
    u_if.start = 1'b0;
    u_if.annul = 1'b0;
    @(posedge clk);
    #1;

    // Reset taking effect at iteration 20.
    u_if.signed_div = 1'b1;
    u_if.opdata1 = -32'sd12345;
    u_if.opdata2 = 32'd17;
    u_if.start = 1'b1;
    @(posedge clk);
    #1;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("rstmid_ready", {63'd0, u_if.ready}, 64'd0);
    chk_eq("rstmid_result", u_if.result, 64'd0);
    rst = 1'b0;
    u_if.start = 1'b0;
    @(posedge clk);
    #1;
    do_op("after_rst", 1'b1, -32'sd12345, 32'd17, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
